// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte from the TX FIFO and sends it as
// start, 7/8 data bits LSB-first, optional parity and one stop bit.
module uart_tx_serializer #(
  parameter int FIFO_LAT = 2,
  parameter int OS_RATE  = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_en,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_n,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int OS_W = $clog2(OS_RATE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
  localparam logic [1:0] WAIT_LAST = 2'((FIFO_LAT > 1) ? (FIFO_LAT - 2) : 0);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t          state;
  logic [OS_W-1:0] os_cnt;
  logic [2:0]      bit_cnt;
  logic [1:0]      wait_cnt;
  logic [7:0]      shift_reg;
  logic            cfg_bit8;
  logic            cfg_parity_en;
  logic            parity_bit;
  logic            timed_state;
  logic            bit_end;

  assign timed_state = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
  assign bit_end = baud_en && (os_cnt == OS_LAST);
  assign tx_busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      os_cnt        <= '0;
      bit_cnt       <= '0;
      wait_cnt      <= '0;
      shift_reg     <= '0;
      cfg_bit8      <= 1'b0;
      cfg_parity_en <= 1'b0;
      parity_bit    <= 1'b0;
      fifo_read_n   <= 1'b1;
      tx            <= 1'b1;
      tx_done       <= 1'b0;
    end else begin
      tx_done     <= 1'b0;
      fifo_read_n <= 1'b1;

      if (timed_state && baud_en) begin
        os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
      end

      // tx follows the state one clock later, so it only ever changes on an edge
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
        PARITY:  tx <= parity_bit;
        default: tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state       <= READ;
            fifo_read_n <= 1'b0;
          end
        end
        READ: begin
          wait_cnt <= '0;
          state    <= (FIFO_LAT == 1) ? LOAD : WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= LOAD;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        LOAD: begin
          shift_reg     <= fifo_data;
          cfg_bit8      <= bit8;
          cfg_parity_en <= parity_en;
          parity_bit    <= (bit8 ? ^fifo_data : ^fifo_data[6:0]) ^ odd_n_even;
          os_cnt        <= '0;
          bit_cnt       <= '0;
          state         <= START;
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_cnt == (cfg_bit8 ? 3'd7 : 3'd6)) begin
              bit_cnt <= '0;
              state   <= cfg_parity_en ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            tx_done     <= 1'b1;
            fifo_read_n <= fifo_empty;
            state       <= fifo_empty ? IDLE : READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: FIFO model feeds bytes, a serial monitor
// decodes tx per baud pulse and compares frames against a scoreboard queue.
module tb_uart_tx_serializer;

  localparam int FIFO_LAT = 2;
  localparam int OS_RATE  = 16;
  localparam int BAUD_DIV = 4;
  localparam int TIMEOUT  = 4000;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_en = 1'b0;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read_n;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  typedef struct {
    logic [7:0] data;
    logic       bit8;
    logic       parity_en;
    logic       odd;
    string      frame;
  } vec_t;

  string      exp_q[$];
  logic [7:0] fifo_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int pops_total = 0;
  int done_pulses = 0;
  int frames_seen = 0;
  int bcnt = 0;
  int lat_cnt = 0;
  logic [7:0] pend = 8'h00;
  logic rd_low = 1'b0;
  logic b2b_mode = 1'b0;

  always #5 clock = ~clock;

  uart_tx_serializer #(.FIFO_LAT(FIFO_LAT), .OS_RATE(OS_RATE)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .baud_en(baud_en),
    .bit8(bit8),
    .parity_en(parity_en),
    .odd_n_even(odd_n_even),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_read_n(fifo_read_n),
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      bcnt = (bcnt + 1) % BAUD_DIV;
      baud_en = (bcnt == 0);
    end
  end

  // FIFO model: data becomes valid FIFO_LAT edges after the pop is sampled, junk before
  initial begin
    forever begin
      @(negedge clock);
      rd_low = reset_n && (fifo_read_n === 1'b0);
      @(posedge clock);
      #1;
      if (!reset_n) begin
        fifo_q.delete();
        lat_cnt = 0;
      end else begin
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) fifo_data = pend;
        end
        if (rd_low) begin
          pops_total++;
          checkOutput("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
          if (fifo_q.size() != 0) begin
            pend = fifo_q.pop_front();
            if (FIFO_LAT == 1) begin
              fifo_data = pend;
            end else begin
              fifo_data = ~pend;
              lat_cnt = FIFO_LAT - 1;
            end
          end
        end
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Serial monitor: pairs tx with the baud pulse of the cycle it reflects
  initial begin
    logic  baud_prev;
    logic  in_frame;
    logic  frame_end;
    logic  grp_val;
    logic  grp_ok;
    logic  gap_pending;
    logic  expb;
    int    pcnt;
    int    bit_idx;
    int    cyc;
    int    done_cyc;
    string cur;
    baud_prev = 1'b0; in_frame = 1'b0; gap_pending = 1'b0;
    grp_val = 1'b1; grp_ok = 1'b1; pcnt = 0; bit_idx = 0; cyc = 0; done_cyc = 0;
    cur = "";
    forever begin
      @(negedge clock);
      cyc++;
      frame_end = 1'b0;
      if (!reset_n) begin
        in_frame = 1'b0;
        baud_prev = 1'b0;
        gap_pending = 1'b0;
        exp_q.delete();
      end else begin
        if (gap_pending && tx === 1'b0) begin
          checkOutput("interframe_gap", 32'((cyc - done_cyc) <= FIFO_LAT + 2 + BAUD_DIV), 32'd1);
          gap_pending = 1'b0;
        end
        if (baud_prev) begin
          if (!in_frame && tx === 1'b0) begin
            checkOutput("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              in_frame = 1'b1;
              pcnt = 0;
              bit_idx = 0;
            end
          end
          if (in_frame) begin
            if (pcnt % OS_RATE == 0) begin
              grp_val = tx;
              grp_ok = 1'b1;
            end else if (tx !== grp_val) begin
              grp_ok = 1'b0;
            end
            pcnt++;
            if (pcnt % OS_RATE == 0) begin
              expb = (cur[bit_idx] == "1");
              checkOutput($sformatf("frame%0d_bit%0d_held", frames_seen, bit_idx), 32'(grp_ok), 32'd1);
              checkOutput($sformatf("frame%0d_bit%0d", frames_seen, bit_idx), 32'(grp_val), 32'(expb));
              bit_idx++;
              if (bit_idx == cur.len()) begin
                checkOutput($sformatf("frame%0d_tx_done", frames_seen), 32'(tx_done), 32'd1);
                frame_end = 1'b1;
                in_frame = 1'b0;
                frames_seen++;
                if (b2b_mode && exp_q.size() != 0) begin
                  checkOutput("pop_after_done", 32'(fifo_read_n), 32'd0);
                  gap_pending = 1'b1;
                  done_cyc = cyc;
                end
              end
            end
          end
        end
        if (tx_done === 1'b1) begin
          done_pulses++;
          if (!frame_end) checkOutput("tx_done_spurious", 32'(tx_done), 32'd0);
        end
        baud_prev = baud_en;
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    bit8 = v.bit8;
    parity_en = v.parity_en;
    odd_n_even = v.odd;
    exp_q.push_back(v.frame);
    fifo_q.push_back(v.data);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || tx_busy !== 1'b0) && n < TIMEOUT) begin
      @(negedge clock);
      n++;
    end
    checkOutput({name, "_drained"}, 32'(n < TIMEOUT), 32'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic waitTxLow(input string name);
    int n = 0;
    while (tx !== 1'b0 && n < TIMEOUT) begin
      @(negedge clock);
      n++;
    end
    checkOutput({name, "_start_seen"}, 32'(n < TIMEOUT), 32'd1);
  endtask

  initial begin
    vec_t vecs[7];
    int   pops0;
    int   done0;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, "0101001011"};
    vecs[1] = '{8'hC3, 1'b0, 1'b1, 1'b0, "0110000111"};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, "00000000011"};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, "01111111111"};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, "00011110001"};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b0, "000000001"};
    vecs[6] = '{8'h01, 1'b0, 1'b1, 1'b1, "0100000001"};

    repeat (3) @(negedge clock);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_read_n", 32'(fifo_read_n), 32'd1);
    checkOutput("reset_busy", 32'(tx_busy), 32'd0);
    checkOutput("reset_done", 32'(tx_done), 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("idle_busy", 32'(tx_busy), 32'd0);
    checkOutput("idle_no_pop", 32'(pops_total), 32'd0);

    for (int i = 0; i < 7; i++) begin
      pops0 = pops_total;
      done0 = done_pulses;
      applyStimulus(vecs[i]);
      waitDrain($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_pops", i), 32'(pops_total - pops0), 32'd1);
      checkOutput($sformatf("vec%0d_done_pulses", i), 32'(done_pulses - done0), 32'd1);
      checkOutput($sformatf("vec%0d_tx_idle", i), 32'(tx), 32'd1);
    end

    // Back-to-back frames from a preloaded FIFO
    b2b_mode = 1'b1;
    pops0 = pops_total;
    done0 = done_pulses;
    applyStimulus('{8'h11, 1'b1, 1'b0, 1'b0, "0100010001"});
    applyStimulus('{8'h22, 1'b1, 1'b0, 1'b0, "0010001001"});
    applyStimulus('{8'h33, 1'b1, 1'b0, 1'b0, "0110011001"});
    waitDrain("b2b");
    checkOutput("b2b_pops", 32'(pops_total - pops0), 32'd3);
    checkOutput("b2b_done_pulses", 32'(done_pulses - done0), 32'd3);

    // Format changes during DATA only take effect on the next frame
    pops0 = pops_total;
    done0 = done_pulses;
    applyStimulus('{8'h5A, 1'b1, 1'b0, 1'b0, "0010110101"});
    waitTxLow("cfg");
    repeat (OS_RATE * 3 * BAUD_DIV) @(negedge clock);
    bit8 = 1'b0;
    parity_en = 1'b1;
    odd_n_even = 1'b1;
    exp_q.push_back("0110000011");
    fifo_q.push_back(8'h03);
    waitDrain("cfg");
    checkOutput("cfg_pops", 32'(pops_total - pops0), 32'd2);
    checkOutput("cfg_done_pulses", 32'(done_pulses - done0), 32'd2);
    b2b_mode = 1'b0;

    // Reset during DATA aborts the frame and must not trigger another pop
    applyStimulus('{8'hA5, 1'b1, 1'b0, 1'b0, "0101001011"});
    waitTxLow("rst");
    repeat (OS_RATE * 3 * BAUD_DIV) @(negedge clock);
    pops0 = pops_total;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_tx", 32'(tx), 32'd1);
    checkOutput("rst_async_read_n", 32'(fifo_read_n), 32'd1);
    checkOutput("rst_async_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (OS_RATE * BAUD_DIV * 2) @(negedge clock);
    checkOutput("rst_after_tx", 32'(tx), 32'd1);
    checkOutput("rst_after_busy", 32'(tx_busy), 32'd0);
    checkOutput("rst_after_no_pop", 32'(pops_total - pops0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit stage of the UART core. It sits directly downstream of the TX byte FIFO.
- It pops one byte at a time from the FIFO through the FIFO's active-low read strobe, then serialises the byte onto the tx line.
- Frame format: start bit, 7 or 8 data bits LSB-first, optional parity bit, one stop bit.
- Bit timing comes from a 16x-oversampled baud enable pulse supplied by the baud generator.

Parameters:
- FIFO_LAT, 2, number of clock edges from the edge that samples fifo_read_n low to the edge after which fifo_data holds the popped byte. Legal range 1..3.
- OS_RATE, 16, baud_en pulses per bit period. Must be a power of 2, 4..16.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- baud_en  in  1  one-clock pulse at OS_RATE x baud rate.
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits.
- parity_en  in  1  1 = append parity bit.
- odd_n_even  in  1  1 = odd parity, 0 = even parity.
- fifo_empty  in  1  TX FIFO empty flag.
- fifo_data  in  8  TX FIFO read data.
- fifo_read_n  out  1  FIFO pop strobe, active low, registered.
- tx  out  1  serial output, idle high, registered.
- tx_busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-clock pulse at the end of each stop bit.

Behaviour:
- Reset values: fifo_read_n=1, tx=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0. Reset asserted mid-frame aborts immediately; the partial frame is lost and the FIFO is not re-read.
- States: IDLE, READ, WAIT, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - If fifo_empty=0 at an edge, go to READ. Otherwise stay.
- READ:
  - Exactly one cycle with fifo_read_n=0. Never more than one pop per frame.
  - Go to WAIT.
- WAIT:
  - Lasts FIFO_LAT-1 cycles, then go to LOAD. With FIFO_LAT=1, WAIT is skipped.
- LOAD:
  - Capture fifo_data into the shift register.
  - Latch bit8, parity_en and odd_n_even. Configuration changes after LOAD have no effect on the current frame.
  - Compute parity over the captured data bits:
    - 8-bit mode: XOR of data[7:0].
    - 7-bit mode: XOR of data[6:0]; data[7] is ignored and never sent.
    - Odd parity inverts the XOR result.
  - Clear the oversample counter and go to START.
- Bit timing:
  - A per-bit counter counts baud_en pulses only in START, DATA, PARITY and STOP.
  - A bit ends at the edge where the OS_RATE-th baud_en pulse of that bit is seen. The counter resets at that edge.
  - baud_en pulses in IDLE, READ, WAIT and LOAD are ignored.
- START: tx=0 for one bit period, then go to DATA.
- DATA:
  - tx = shift register bit 0; shift right at the end of each bit.
  - A bit counter counts 8 bits (bit8=1) or 7 bits (bit8=0).
  - After the last bit: go to PARITY if parity_en=1, else STOP.
- PARITY: tx = computed parity bit for one bit period, then go to STOP.
- STOP:
  - tx=1 for one bit period.
  - At the final edge of the stop bit: pulse tx_done=1 for the following cycle.
  - If fifo_empty=0 at that edge, go to READ (back-to-back frames). Otherwise go to IDLE.
- Frame length in baud_en pulses: OS_RATE x (1 + N + P + 1), where N is 7 or 8 and P is 0 or 1.
- Inter-frame idle on tx between back-to-back frames: FIFO_LAT+1 clocks, plus the wait for the next baud_en.
- tx is registered. A level change appears one clock after the state or shift transition, with no glitches.
- fifo_empty is sampled only in IDLE and at the end of STOP. Its value during READ, WAIT or LOAD is ignored.

Test Plan:
- Reset check: assert reset_n=0 mid-DATA -> tx=1, fifo_read_n=1 and tx_busy=0 asynchronously; after release, IDLE with no FIFO pop.
- Single byte, 8N1: FIFO holds 0xA5, bit8=1, parity_en=0 -> exactly one fifo_read_n low cycle; tx = 0,1,0,1,0,0,1,0,1,1, each level held for 16 baud_en; one tx_done pulse; return to IDLE.
- 7E1: fifo_data=0xC3, bit8=0, parity_en=1, odd_n_even=0 -> data bits 1,1,0,0,0,0,1; bit 7 not sent; parity bit 1 (XOR of 0x43 = 1); frame of 10 bits = 160 baud_en.
- 8O1: fifo_data=0x00, parity_en=1, odd_n_even=1 -> parity bit 1. Then fifo_data=0xFF -> parity bit 1.
- Back-to-back: FIFO holds 0x11, 0x22, 0x33 -> three fifo_read_n pulses; each pulse falls in the first clock after the previous tx_done edge; tx stays high between stop bit and next start bit for at most FIFO_LAT+1 clocks plus one baud_en interval.
- Config change mid-frame: toggle bit8 and parity_en during DATA of byte 0x5A -> current frame keeps the format latched at LOAD; the next frame uses the new settings.
